// File: rtl/idma_desc64_synth_pkg.sv
// Burst request type shared by the desc64 frontends and the iDMA backend.
package idma_desc64_synth_pkg;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] src;
    logic [63:0] dst;
    logic [63:0] num_bytes;
    logic [3:0]  cache;
    logic [1:0]  burst;
    logic        decouple_rw;
    logic        deburst;
    logic        serialize;
  } burst_req_t;

endpackage

// File: rtl/idma_desc64_burst_arbiter.sv
// Round-robin arbiter sharing one iDMA backend burst port among NumReq frontends;
// an in-order FIFO of granted indices routes each completion back to its owner.
module idma_desc64_burst_arbiter #(
  parameter int unsigned NumReq         = 2,
  parameter int unsigned MaxOutstanding = 8,
  parameter type         burst_req_t    = idma_desc64_synth_pkg::burst_req_t
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  burst_req_t [NumReq-1:0] req_i,
  input  logic       [NumReq-1:0] req_valid_i,
  output logic       [NumReq-1:0] req_ready_o,
  output logic       [NumReq-1:0] rsp_valid_o,
  output burst_req_t              backend_req_o,
  output logic                    backend_valid_o,
  input  logic                    backend_ready_i,
  input  logic                    backend_rsp_valid_i,
  output logic                    busy_o,
  output logic                    err_o
);

  localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned PtrW = $clog2(MaxOutstanding);

  typedef logic [IdxW-1:0] idx_t;
  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [PtrW:0]   cnt_t;

  idx_t last_q;
  logic lock_q;
  idx_t lock_idx_q;
  idx_t fifo_q [MaxOutstanding];
  ptr_t wr_ptr_q, rd_ptr_q;
  cnt_t cnt_q;
  logic err_q;

  idx_t grant, cand;
  logic grant_vld;
  logic full, handshake, pop;

  // A stalled grant stays locked so the backend sees a stable request.
  always_comb begin
    grant     = lock_idx_q;
    grant_vld = 1'b0;
    cand      = '0;
    if (lock_q) begin
      grant_vld = req_valid_i[lock_idx_q];
    end else begin
      for (int unsigned i = 1; i <= NumReq; i++) begin
        cand = idx_t'((int'(last_q) + i) % NumReq);
        if (!grant_vld && req_valid_i[cand]) begin
          grant     = cand;
          grant_vld = 1'b1;
        end
      end
    end
  end

  // Full blocks issue even when a completion frees a slot this cycle.
  assign full            = (cnt_q == cnt_t'(MaxOutstanding));
  assign backend_valid_o = grant_vld & ~full;
  assign handshake       = backend_valid_o & backend_ready_i;
  assign backend_req_o   = req_i[grant];
  assign pop             = backend_rsp_valid_i & (cnt_q != '0);
  assign busy_o          = (cnt_q != '0) | (|req_valid_i);
  assign err_o           = err_q;

  always_comb begin
    req_ready_o        = '0;
    req_ready_o[grant] = handshake;
    rsp_valid_o        = '0;
    if (pop) begin
      rsp_valid_o[fifo_q[rd_ptr_q]] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      last_q     <= idx_t'(NumReq - 1);
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      if (handshake) begin
        last_q   <= grant;
        lock_q   <= 1'b0;
        wr_ptr_q <= wr_ptr_q + ptr_t'(1);
      end else if (backend_valid_o) begin
        lock_q     <= 1'b1;
        lock_idx_q <= grant;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + ptr_t'(1);
      end
      if (backend_rsp_valid_i && (cnt_q == '0)) begin
        err_q <= 1'b1;
      end
      case ({handshake, pop})
        2'b10:   cnt_q <= cnt_q + cnt_t'(1);
        2'b01:   cnt_q <= cnt_q - cnt_t'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (handshake) begin
      fifo_q[wr_ptr_q] <= grant;
    end
  end

endmodule

// File: tb/tb_idma_desc64_burst_arbiter.sv
// Directed bench for idma_desc64_burst_arbiter with NumReq=2, MaxOutstanding=8.
module tb_idma_desc64_burst_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  idma_desc64_synth_pkg::burst_req_t [1:0] req;
  logic [1:0] req_valid, req_ready, rsp_valid;
  idma_desc64_synth_pkg::burst_req_t backend_req;
  logic backend_valid, backend_ready, backend_rsp_valid, busy, err;

  int tests = 0;
  int fails = 0;

  idma_desc64_burst_arbiter #(
    .NumReq(2),
    .MaxOutstanding(8),
    .burst_req_t(idma_desc64_synth_pkg::burst_req_t)
  ) dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .req_i              (req),
    .req_valid_i        (req_valid),
    .req_ready_o        (req_ready),
    .rsp_valid_o        (rsp_valid),
    .backend_req_o      (backend_req),
    .backend_valid_o    (backend_valid),
    .backend_ready_i    (backend_ready),
    .backend_rsp_valid_i(backend_rsp_valid),
    .busy_o             (busy),
    .err_o              (err)
  );

  always #5 clk = ~clk;

  // Inputs change 1 unit after the rising edge; checks happen 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 2'b00; backend_ready = 1'b0; backend_rsp_valid = 1'b0;
    tick(); tick();
    #1;
    tests++;
    if ({req_ready, rsp_valid, backend_valid, busy, err} !== 7'b0) begin
      fails++; $display("FAIL reset_outputs got=%b exp=0000000", {req_ready, rsp_valid, backend_valid, busy, err});
    end
    tick(); rst_n = 1'b1;
    tick(); #1;
    tests++;
    if ({req_ready, rsp_valid, backend_valid, busy, err} !== 7'b0) begin
      fails++; $display("FAIL post_reset_outputs got=%b exp=0000000", {req_ready, rsp_valid, backend_valid, busy, err});
    end
  endtask

  task automatic test_single();
    tick(); req_valid = 2'b10; backend_ready = 1'b1; #1;
    tests++;
    if (backend_valid !== 1'b1 || req_ready !== 2'b10 || backend_req.id !== 4'h2) begin
      fails++; $display("FAIL single_issue got vld=%b rdy=%b id=%h exp vld=1 rdy=10 id=2", backend_valid, req_ready, backend_req.id);
    end
    tick(); req_valid = 2'b00;
    tick(); tick(); tick(); #1;
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL single_busy_outstanding got=%b exp=1", busy); end
    tick(); backend_rsp_valid = 1'b1; #1;
    tests++;
    if (rsp_valid !== 2'b10) begin fails++; $display("FAIL single_rsp got=%b exp=10", rsp_valid); end
    tick(); backend_rsp_valid = 1'b0; #1;
    tests++;
    if (rsp_valid !== 2'b00 || busy !== 1'b0) begin
      fails++; $display("FAIL single_done got rsp=%b busy=%b exp rsp=00 busy=0", rsp_valid, busy);
    end
  endtask

  task automatic test_fairness();
    logic [1:0] exp;
    for (int i = 0; i < 4; i++) begin
      tick(); req_valid = 2'b11; backend_ready = 1'b1; #1;
      exp = (i % 2 == 0) ? 2'b01 : 2'b10;
      tests++;
      if (req_ready !== exp) begin fails++; $display("FAIL fair_grant%0d got=%b exp=%b", i, req_ready, exp); end
    end
    tick(); req_valid = 2'b00;
    for (int i = 0; i < 4; i++) begin
      tick(); backend_rsp_valid = 1'b1; #1;
      exp = (i % 2 == 0) ? 2'b01 : 2'b10;
      tests++;
      if (rsp_valid !== exp) begin fails++; $display("FAIL fair_rsp%0d got=%b exp=%b", i, rsp_valid, exp); end
    end
    tick(); backend_rsp_valid = 1'b0; #1;
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL fair_idle got=%b exp=0", busy); end
  endtask

  task automatic test_lock();
    // Grant frontend 0 once so an unlocked scan would now favour frontend 1.
    tick(); req_valid = 2'b01; backend_ready = 1'b1;
    tick(); backend_ready = 1'b0; #1;
    tests++;
    if (backend_valid !== 1'b1 || req_ready !== 2'b00 || backend_req.id !== 4'h1) begin
      fails++; $display("FAIL lock_stall got vld=%b rdy=%b id=%h exp vld=1 rdy=00 id=1", backend_valid, req_ready, backend_req.id);
    end
    for (int i = 1; i < 3; i++) begin
      tick(); req_valid = 2'b11; #1;
      tests++;
      if (backend_req.id !== 4'h1 || req_ready !== 2'b00) begin
        fails++; $display("FAIL lock_hold%0d got id=%h rdy=%b exp id=1 rdy=00", i, backend_req.id, req_ready);
      end
    end
    tick(); backend_ready = 1'b1; #1;
    tests++;
    if (req_ready !== 2'b01) begin fails++; $display("FAIL lock_release got=%b exp=01", req_ready); end
    tick(); req_valid = 2'b10; #1;
    tests++;
    if (req_ready !== 2'b10) begin fails++; $display("FAIL lock_next got=%b exp=10", req_ready); end
    tick(); req_valid = 2'b00;
    for (int i = 0; i < 3; i++) begin
      tick(); backend_rsp_valid = 1'b1; #1;
      tests++;
      if (rsp_valid !== ((i < 2) ? 2'b01 : 2'b10)) begin fails++; $display("FAIL lock_rsp%0d got=%b", i, rsp_valid); end
    end
    tick(); backend_rsp_valid = 1'b0;
  endtask

  task automatic test_full();
    for (int i = 0; i < 8; i++) begin
      tick(); req_valid = 2'b01; backend_ready = 1'b1; #1;
      tests++;
      if (req_ready !== 2'b01) begin fails++; $display("FAIL full_fill%0d got=%b exp=01", i, req_ready); end
    end
    tick(); #1;
    tests++;
    if (backend_valid !== 1'b0 || req_ready !== 2'b00 || busy !== 1'b1) begin
      fails++; $display("FAIL full_block got vld=%b rdy=%b busy=%b exp 0 00 1", backend_valid, req_ready, busy);
    end
    tick(); backend_rsp_valid = 1'b1; #1;
    tests++;
    if (backend_valid !== 1'b0 || rsp_valid !== 2'b01) begin
      fails++; $display("FAIL full_pop_block got vld=%b rsp=%b exp vld=0 rsp=01", backend_valid, rsp_valid);
    end
    tick(); backend_rsp_valid = 1'b0; #1;
    tests++;
    if (backend_valid !== 1'b1 || req_ready !== 2'b01) begin
      fails++; $display("FAIL full_resume got vld=%b rdy=%b exp vld=1 rdy=01", backend_valid, req_ready);
    end
    tick(); req_valid = 2'b00;
    for (int i = 0; i < 8; i++) begin
      tick(); backend_rsp_valid = 1'b1; #1;
      tests++;
      if (rsp_valid !== 2'b01) begin fails++; $display("FAIL full_drain%0d got=%b exp=01", i, rsp_valid); end
    end
    tick(); backend_rsp_valid = 1'b0; #1;
    tests++;
    if (busy !== 1'b0 || err !== 1'b0) begin
      fails++; $display("FAIL full_idle got busy=%b err=%b exp 0 0", busy, err);
    end
  endtask

  task automatic test_spurious();
    tick(); rst_n = 1'b0;
    tick(); rst_n = 1'b1;
    tick(); backend_rsp_valid = 1'b1; #1;
    tests++;
    if (rsp_valid !== 2'b00) begin fails++; $display("FAIL spur_rsp got=%b exp=00", rsp_valid); end
    tick(); backend_rsp_valid = 1'b0; #1;
    tests++;
    if (err !== 1'b1) begin fails++; $display("FAIL spur_err got=%b exp=1", err); end
    tick(); tick(); tick(); #1;
    tests++;
    if (err !== 1'b1) begin fails++; $display("FAIL spur_err_sticky got=%b exp=1", err); end
    rst_n = 1'b0;
    tick(); rst_n = 1'b1; #1;
    tests++;
    if (err !== 1'b0) begin fails++; $display("FAIL spur_err_clear got=%b exp=0", err); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      tick(); req_valid = 2'b01; backend_ready = 1'b1;
    end
    tick(); req_valid = 2'b00; rst_n = 1'b0;
    tick(); rst_n = 1'b1; #1;
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL mid_busy got=%b exp=0", busy); end
    req_valid = 2'b11; #1;
    tests++;
    if (req_ready !== 2'b01) begin fails++; $display("FAIL mid_first_grant got=%b exp=01", req_ready); end
    tick(); req_valid = 2'b00; backend_rsp_valid = 1'b1; #1;
    tests++;
    if (rsp_valid !== 2'b01) begin fails++; $display("FAIL mid_rsp got=%b exp=01", rsp_valid); end
    tick(); #1;
    tests++;
    if (rsp_valid !== 2'b00) begin fails++; $display("FAIL mid_rsp_extra got=%b exp=00", rsp_valid); end
    tick(); backend_rsp_valid = 1'b0; #1;
    tests++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL mid_err got err=%b busy=%b exp 1 0", err, busy);
    end
  endtask

  initial begin
    req = '0;
    req[0].id = 4'h1;
    req[0].src = 64'h1000;
    req[1].id = 4'h2;
    req[1].src = 64'h2000;
    test_reset();
    test_single();
    test_fairness();
    test_lock();
    test_full();
    test_spurious();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
